// File: rtl/psola_playback_buffer.sv
// Ping-pong frame buffer: captures one PSOLA frame while replaying the previous one at a fixed sample rate.
// Each rate tick yields a sample 3 cycles later (2-cycle RAM read + output register); no backpressure, sinks must keep pace.
module psola_playback_buffer #(
  parameter int WIDTH         = 32,
  parameter int MAX_FRAME     = 2200,
  parameter int HOLD_CYCLES   = 2304,
  parameter int OUT_WIDTH     = 16,
  parameter int OUT_LSB       = 14,
  parameter bit LOOP_UNDERRUN = 1'b1
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [WIDTH-1:0]             wr_data_in,
  input  logic [$clog2(MAX_FRAME)-1:0] wr_addr_in,
  input  logic                         wr_valid_in,
  input  logic                         wr_done_in,
  output logic [OUT_WIDTH-1:0]         sample_out,
  output logic                         sample_valid_out,
  output logic [$clog2(MAX_FRAME)-1:0] play_addr_out,
  output logic                         swap_out,
  output logic                         underrun_out,
  output logic                         overflow_out
);
  localparam int AW  = $clog2(MAX_FRAME);
  localparam int LW  = $clog2(MAX_FRAME + 1);
  localparam int RAW = $clog2(2 * MAX_FRAME);
  localparam int HW  = $clog2(HOLD_CYCLES);
  localparam logic [AW:0] FRAME_LIM = (AW+1)'(MAX_FRAME);

  typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;
  typedef struct packed {
    logic vld;
    logic ram;
    logic und;
  } pipe_t;

  state_t               state, state_d;
  logic                 play_bank;
  logic [LW-1:0]        wr_len, play_len, wr_len_d, wr_addr_p1;
  logic [AW-1:0]        play_addr;
  logic [HW-1:0]        hold_cnt;
  pipe_t                p1, p2;
  logic [OUT_WIDTH-1:0] ram_q1, ram_q2;
  logic [WIDTH-1:0]     mem [2*MAX_FRAME];
  logic                 wr_ok, swap, tick, play_tick, last;
  logic [RAW-1:0]       wr_ram_addr, rd_ram_addr;

  // The write bank is always the complement of the play bank.
  always_comb begin
    wr_ok       = wr_valid_in && ({1'b0, wr_addr_in} < FRAME_LIM);
    wr_addr_p1  = LW'(wr_addr_in) + LW'(1);
    wr_len_d    = (wr_ok && (wr_addr_p1 > wr_len)) ? wr_addr_p1 : wr_len;
    swap        = wr_done_in && (wr_len_d != '0);
    tick        = (hold_cnt == '0);
    play_tick   = tick && (state == PLAY);
    last        = ((LW'(play_addr) + LW'(1)) == play_len);
    wr_ram_addr = RAW'(wr_addr_in) + (play_bank ? RAW'(0) : RAW'(MAX_FRAME));
    rd_ram_addr = RAW'(play_addr) + (play_bank ? RAW'(MAX_FRAME) : RAW'(0));
  end

  always_ff @(posedge clk_in) begin
    if (wr_ok) mem[wr_ram_addr] <= wr_data_in;
    if (play_tick) ram_q1 <= mem[rd_ram_addr][OUT_LSB +: OUT_WIDTH];
    ram_q2 <= ram_q1;
  end

  always_comb begin
    state_d = state;
    if (swap) state_d = PLAY;
    else if (play_tick && last && !LOOP_UNDERRUN) state_d = DRAIN;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_d;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      play_bank        <= 1'b0;
      wr_len           <= '0;
      play_len         <= '0;
      play_addr        <= '0;
      hold_cnt         <= '0;
      p1               <= '0;
      p2               <= '0;
      sample_out       <= '0;
      sample_valid_out <= 1'b0;
      play_addr_out    <= '0;
      swap_out         <= 1'b0;
      underrun_out     <= 1'b0;
      overflow_out     <= 1'b0;
    end else begin
      overflow_out <= overflow_out | (wr_valid_in & ~wr_ok);
      swap_out     <= swap;
      if (swap) begin
        // Restart playback on the new frame; anything still in the read pipe belongs to the old one.
        play_bank        <= ~play_bank;
        play_len         <= wr_len_d;
        wr_len           <= '0;
        play_addr        <= '0;
        hold_cnt         <= '0;
        p1               <= '0;
        p2               <= '0;
        sample_valid_out <= 1'b0;
        underrun_out     <= 1'b0;
      end else begin
        wr_len           <= wr_len_d;
        hold_cnt         <= (hold_cnt == HW'(HOLD_CYCLES - 1)) ? '0 : hold_cnt + 1'b1;
        p1               <= '{vld: tick, ram: play_tick, und: play_tick && last};
        p2               <= p1;
        sample_valid_out <= p2.vld;
        underrun_out     <= p2.und;
        if (p2.vld) sample_out <= p2.ram ? ram_q2 : '0;
        if (play_tick) begin
          play_addr_out <= play_addr;
          play_addr     <= last ? '0 : play_addr + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_psola_playback_buffer.sv
// Bench for psola_playback_buffer: a looping and a draining instance share one directed stimulus stream.
module tb_psola_playback_buffer;
  localparam int WIDTH     = 32;
  localparam int MAX_FRAME = 12;
  localparam int HOLD      = 8;
  localparam int OW        = 16;
  localparam int LSB       = 14;
  localparam int AW        = $clog2(MAX_FRAME);

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic [WIDTH-1:0] wr_data_in;
  logic [AW-1:0]    wr_addr_in;
  logic             wr_valid_in, wr_done_in;
  logic [OW-1:0]    samp [2];
  logic             sv   [2];
  logic [AW-1:0]    pao  [2];
  logic             swp  [2];
  logic             und  [2];
  logic             ovf  [2];

  always #5 clk_in = ~clk_in;

  psola_playback_buffer #(
    .WIDTH(WIDTH), .MAX_FRAME(MAX_FRAME), .HOLD_CYCLES(HOLD),
    .OUT_WIDTH(OW), .OUT_LSB(LSB), .LOOP_UNDERRUN(1'b1)
  ) dut_loop (
    .clk_in(clk_in), .rst_in(rst_in), .wr_data_in(wr_data_in), .wr_addr_in(wr_addr_in),
    .wr_valid_in(wr_valid_in), .wr_done_in(wr_done_in), .sample_out(samp[0]),
    .sample_valid_out(sv[0]), .play_addr_out(pao[0]), .swap_out(swp[0]),
    .underrun_out(und[0]), .overflow_out(ovf[0])
  );

  psola_playback_buffer #(
    .WIDTH(WIDTH), .MAX_FRAME(MAX_FRAME), .HOLD_CYCLES(HOLD),
    .OUT_WIDTH(OW), .OUT_LSB(LSB), .LOOP_UNDERRUN(1'b0)
  ) dut_drain (
    .clk_in(clk_in), .rst_in(rst_in), .wr_data_in(wr_data_in), .wr_addr_in(wr_addr_in),
    .wr_valid_in(wr_valid_in), .wr_done_in(wr_done_in), .sample_out(samp[1]),
    .sample_valid_out(sv[1]), .play_addr_out(pao[1]), .swap_out(swp[1]),
    .underrun_out(und[1]), .overflow_out(ovf[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit armed  = 1'b0;

  // Model: two banks of frame samples, a play cursor, and a schedule of pulses due 3 cycles after each tick.
  int m_ram   [2][2][MAX_FRAME];
  int m_pb    [2];
  int m_mode  [2];   // 0 idle, 1 play, 2 drain
  int m_wlen  [2];
  int m_plen  [2];
  int m_paddr [2];
  int m_phase [2];
  bit sched_v [2][4];
  int sched_d [2][4];
  bit sched_u [2][4];
  int e_sample[2];
  int e_paddr [2];
  bit e_valid [2];
  bit e_und   [2];
  bit e_swap  [2];
  bit e_ovf   [2];

  int obs_s   [2][32];
  int obs_u   [2][32];
  int obs_c   [2][32];
  int obs_n   [2];
  int mlog_s  [2][32];
  int mlog_n  [2];
  int swap_cnt[2];
  int swap_cyc[2];
  int slot;

  int seq_loop  [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int seq_drain [8] = '{0, 1, 2, 3, 0, 0, 0, 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!rst_in) begin
        armed = 1'b1;
        m_pb[i] = 0; m_mode[i] = 0; m_wlen[i] = 0; m_plen[i] = 0;
        m_paddr[i] = 0; m_phase[i] = 0;
        e_sample[i] = 0; e_paddr[i] = 0; e_swap[i] = 1'b0; e_ovf[i] = 1'b0;
        for (int k = 0; k < 4; k++) sched_v[i][k] = 1'b0;
      end else if (armed) begin
        bit ok, swap, lastsmp;
        int wl, due;
        ok = wr_valid_in && (int'(wr_addr_in) < MAX_FRAME);
        if (wr_valid_in && !ok) e_ovf[i] = 1'b1;
        wl = m_wlen[i];
        if (ok) begin
          m_ram[i][1 - m_pb[i]][wr_addr_in] = int'((wr_data_in >> LSB) % (1 << OW));
          if (int'(wr_addr_in) + 1 > wl) wl = int'(wr_addr_in) + 1;
        end
        swap = wr_done_in && (wl > 0);
        e_swap[i] = swap;
        if (swap) begin
          m_pb[i] = 1 - m_pb[i]; m_plen[i] = wl; m_wlen[i] = 0;
          m_paddr[i] = 0; m_mode[i] = 1; m_phase[i] = 0;
          for (int k = 0; k < 4; k++) sched_v[i][k] = 1'b0;
        end else begin
          m_wlen[i] = wl;
          if (m_phase[i] == 0) begin
            due = (cyc + 3) % 4;
            sched_v[i][due] = 1'b1;
            sched_d[i][due] = 0;
            sched_u[i][due] = 1'b0;
            if (m_mode[i] == 1) begin
              lastsmp = (m_paddr[i] + 1 == m_plen[i]);
              sched_d[i][due] = m_ram[i][m_pb[i]][m_paddr[i]];
              sched_u[i][due] = lastsmp;
              e_paddr[i] = m_paddr[i];
              if (lastsmp) begin
                m_paddr[i] = 0;
                if (i == 1) m_mode[i] = 2;
              end else begin
                m_paddr[i] = m_paddr[i] + 1;
              end
            end
          end
          m_phase[i] = (m_phase[i] + 1) % HOLD;
        end
      end
    end
  endtask

  always @(negedge clk_in) begin
    for (int i = 0; i < 2; i++) begin
      slot = cyc % 4;
      e_valid[i] = sched_v[i][slot];
      e_und[i]   = sched_v[i][slot] && sched_u[i][slot];
      if (sched_v[i][slot]) e_sample[i] = sched_d[i][slot];
      sched_v[i][slot] = 1'b0;
      if (armed) begin
        chk($sformatf("sample_out[%0d] cyc %0d", i, cyc), int'(samp[i]), e_sample[i]);
        chk($sformatf("sample_valid_out[%0d] cyc %0d", i, cyc), int'(sv[i]), int'(e_valid[i]));
        chk($sformatf("play_addr_out[%0d] cyc %0d", i, cyc), int'(pao[i]), e_paddr[i]);
        chk($sformatf("swap_out[%0d] cyc %0d", i, cyc), int'(swp[i]), int'(e_swap[i]));
        chk($sformatf("underrun_out[%0d] cyc %0d", i, cyc), int'(und[i]), int'(e_und[i]));
        chk($sformatf("overflow_out[%0d] cyc %0d", i, cyc), int'(ovf[i]), int'(e_ovf[i]));
        if (swp[i]) begin
          swap_cnt[i]++;
          swap_cyc[i] = cyc;
          obs_n[i] = 0;
        end
        if (sv[i] && obs_n[i] < 32) begin
          obs_s[i][obs_n[i]] = int'(samp[i]);
          obs_u[i][obs_n[i]] = int'(und[i]);
          obs_c[i][obs_n[i]] = cyc;
          obs_n[i]++;
        end
        if (e_swap[i]) mlog_n[i] = 0;
        if (e_valid[i] && mlog_n[i] < 32) begin
          mlog_s[i][mlog_n[i]] = e_sample[i];
          mlog_n[i]++;
        end
      end
    end
    model_step();
    cyc++;
  end

  task automatic step_clk();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input bit v, input int a, input int d, input bit done);
    wr_valid_in = v;
    wr_addr_in  = AW'(a);
    wr_data_in  = WIDTH'(d) << LSB;
    wr_done_in  = done;
    step_clk();
    wr_valid_in = 1'b0;
    wr_done_in  = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    repeat (3) step_clk();
    rst_in = 1'b1;
  endtask

  task automatic begin_log();
    for (int i = 0; i < 2; i++) begin
      obs_n[i] = 0; mlog_n[i] = 0; swap_cnt[i] = 0; swap_cyc[i] = -100;
    end
  endtask

  task automatic wait_obs(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while ((obs_n[0] < n || obs_n[1] < n) && k < budget) begin
      step_clk();
      k++;
    end
    chk($sformatf("%s pulses within %0d cycles (1=yes)", tag, budget),
        int'(obs_n[0] >= n && obs_n[1] >= n), 1);
  endtask

  task automatic chk_pulse(input string tag, input int i, input int k, input int es, input int eu);
    chk($sformatf("%s dut%0d sample#%0d", tag, i, k), obs_s[i][k], es);
    chk($sformatf("%s dut%0d underrun#%0d", tag, i, k), obs_u[i][k], eu);
    chk($sformatf("%s model%0d sample#%0d", tag, i, k), mlog_s[i][k], es);
  endtask

  initial begin
    rst_in = 1'b0; wr_data_in = '0; wr_addr_in = '0; wr_valid_in = 1'b0; wr_done_in = 1'b0;
    begin_log();

    // Idle after reset: three zero pulses per 3*HOLD cycles, no flags.
    do_reset();
    begin_log();
    repeat (3 * HOLD) step_clk();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("idle dut%0d pulse count", i), obs_n[i], 3);
      chk($sformatf("idle model%0d pulse count", i), mlog_n[i], 3);
      for (int k = 0; k < 3; k++) chk_pulse("idle", i, k, 0, 0);
      chk($sformatf("idle dut%0d swaps", i), swap_cnt[i], 0);
    end

    // Ten-sample frame, played back in order starting 3 cycles after swap_out.
    for (int k = 0; k < 10; k++) drive(1'b1, k, k, 1'b0);
    drive(1'b0, 0, 0, 1'b1);
    begin_log();
    wait_obs("frame10", 10, 120);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("frame10 dut%0d swaps", i), swap_cnt[i], 1);
      chk($sformatf("frame10 dut%0d first pulse delay", i), obs_c[i][0] - swap_cyc[i], 3);
      for (int k = 0; k < 10; k++) chk_pulse("frame10", i, k, k, int'(k == 9));
    end

    // Four-sample frame, last write together with wr_done: loop vs drain policy.
    do_reset();
    for (int k = 0; k < 3; k++) drive(1'b1, k, k, 1'b0);
    drive(1'b1, 3, 3, 1'b1);
    begin_log();
    wait_obs("frame4", 8, 100);
    for (int k = 0; k < 8; k++) begin
      chk_pulse("frame4 loop", 0, k, seq_loop[k], int'(k == 3 || k == 7));
      chk_pulse("frame4 drain", 1, k, seq_drain[k], int'(k == 3));
    end

    // Frame B completes while frame A is mid-playback: A is abandoned, B starts at index 0.
    do_reset();
    for (int k = 0; k < 8; k++) drive(1'b1, k, 100 + k, 1'b0);
    drive(1'b0, 0, 0, 1'b1);
    begin_log();
    wait_obs("frameA", 3, 60);
    for (int i = 0; i < 2; i++) chk_pulse("frameA", i, 2, 102, 0);
    for (int k = 0; k < 5; k++) drive(1'b1, k, 200 + k, 1'b0);
    drive(1'b0, 0, 0, 1'b1);
    begin_log();
    wait_obs("frameB", 5, 80);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("frameB dut%0d swaps", i), swap_cnt[i], 1);
      chk($sformatf("frameB dut%0d first pulse delay", i), obs_c[i][0] - swap_cyc[i], 3);
      for (int k = 0; k < 5; k++) chk_pulse("frameB", i, k, 200 + k, int'(k == 4));
    end

    // Out-of-range write: sticky overflow, frame length untouched so wr_done is ignored.
    do_reset();
    begin_log();
    drive(1'b1, MAX_FRAME, 5, 1'b0);
    drive(1'b0, 0, 0, 1'b1);
    repeat (20) step_clk();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("overflow dut%0d flag", i), int'(ovf[i]), 1);
      chk($sformatf("overflow model%0d flag", i), int'(e_ovf[i]), 1);
      chk($sformatf("overflow dut%0d swaps", i), swap_cnt[i], 0);
    end
    do_reset();
    step_clk();
    for (int i = 0; i < 2; i++) chk($sformatf("overflow dut%0d cleared by reset", i), int'(ovf[i]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
